// File: rtl/rca_pkg.sv
// rtl/rca_pkg.sv - shared state type and sizing helper for the sequential ripple-carry adder
package rca_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Digit counter width; never narrower than one bit so NDIG=1 still has a counter.
   function automatic int cnt_width(input int ndig);
      return (ndig > 1) ? $clog2(ndig) : 1;
   endfunction

endpackage

// File: rtl/rca_slice.sv
// rtl/rca_slice.sv - combinational DIGIT-bit ripple-carry slice
module rca_slice #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   output logic [DIGIT-1:0] sum,
   output logic             cout,
   output logic             c_msb
);

   logic [DIGIT:0] c;

   // Ripple the carry bit by bit through the slice.
   always_comb begin
      sum  = '0;
      c    = '0;
      c[0] = cin;
      for (int i = 0; i < DIGIT; i++) begin
         sum[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign cout  = c[DIGIT];
   assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/rca_seq_adder.sv
// rtl/rca_seq_adder.sv - multi-cycle ripple-carry adder, one digit per clock (RCA_SUB_EN adds subtract)
module rca_seq_adder
   import rca_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef RCA_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   localparam int             NDIG = WIDTH / DIGIT;
   localparam int             CW   = cnt_width(NDIG);
   localparam logic [CW-1:0]  LAST = CW'(NDIG - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic [DIGIT-1:0] slice_sum;
   logic             slice_cout;
   logic             slice_c_msb;
   logic [WIDTH-1:0] sum_next;

   logic [WIDTH-1:0] b_load;
   logic             c_load;

`ifdef RCA_SUB_EN
   // Subtract is A + ~B + 1, so the incoming carry is forced high and cin is ignored.
   assign b_load = sub ? ~b : b;
   assign c_load = sub | cin;
`else
   assign b_load = b;
   assign c_load = cin;
`endif

   rca_slice #(.DIGIT(DIGIT)) u_slice (
      .a     (a_sr[DIGIT-1:0]),
      .b     (b_sr[DIGIT-1:0]),
      .cin   (carry),
      .sum   (slice_sum),
      .cout  (slice_cout),
      .c_msb (slice_c_msb)
   );

   generate
      if (NDIG == 1) begin : g_one
         assign sum_next = slice_sum;
      end else begin : g_multi
         logic [WIDTH-DIGIT-1:0] part;

         // Partial sum shifts right; each new digit enters at the top.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               part <= '0;
            else if (state == RUN)
               part <= sum_next[WIDTH-1:DIGIT];
         end

         assign sum_next = {slice_sum, part};
      end
   endgenerate

   // Control FSM with operand shifting, carry chaining and registered results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         a_sr  <= '0;
         b_sr  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         s     <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  a_sr  <= a;
                  b_sr  <= b_load;
                  carry <= c_load;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            RUN: begin
               a_sr  <= a_sr >> DIGIT;
               b_sr  <= b_sr >> DIGIT;
               carry <= slice_cout;
               cnt   <= cnt + 1'b1;
               if (cnt == LAST) begin
                  s     <= sum_next;
                  cout  <= slice_cout;
                  ovf   <= slice_c_msb ^ slice_cout;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rca_seq_adder.sv
// tb/tb_rca_seq_adder.sv - randomized self-checking bench for rca_seq_adder
module tb_rca_seq_adder;

   localparam int W  = 16;
   localparam int D  = 4;
   localparam int ND = W / D;
`ifdef RCA_SUB_EN
   localparam bit HAS_SUB = 1'b1;
`else
   localparam bit HAS_SUB = 1'b0;
`endif

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
`ifdef RCA_SUB_EN
   logic         sub_r;
`endif
   logic         busy;
   logic         done;
   logic [W-1:0] s;
   logic         cout;
   logic         ovf;

   int n_cmp;
   int n_err;

   logic [W-1:0] exp_s;
   logic         exp_cout;
   logic         exp_ovf;

   rca_seq_adder #(.WIDTH(W), .DIGIT(D)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
`ifdef RCA_SUB_EN
      .sub   (sub_r),
`endif
      .busy  (busy),
      .done  (done),
      .s     (s),
      .cout  (cout),
      .ovf   (ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   // Reference: plain wide arithmetic, signed overflow from operand/result signs.
   function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic mcin, input logic msub);
      logic [W-1:0] bb;
      logic         c0;
      logic [W:0]   full;
      logic         v;
      bb   = msub ? ~mb : mb;
      c0   = msub ? 1'b1 : mcin;
      full = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, c0};
      v    = (ma[W-1] == bb[W-1]) && (full[W-1] != ma[W-1]);
      return {v, full[W], full[W-1:0]};
   endfunction

   task automatic idle_cycle();
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
   endtask

   // Entered at a negedge while the DUT is IDLE or DONE; returns at the negedge of the DONE cycle.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tcin, input logic tsub, input bit poke);
      logic [W+1:0] e;
      e     = model(ta, tb_v, tcin, tsub);
      start = 1'b1;
      a     = ta;
      b     = tb_v;
      cin   = tcin;
`ifdef RCA_SUB_EN
      sub_r = tsub;
`endif
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 1; i <= ND; i++) begin
         @(negedge clk);
         check("run_busy", 32'(busy), 32'd1);
         check("run_done", 32'(done), 32'd0);
         check("run_s_hold", 32'(s), 32'(exp_s));
         check("run_cout_hold", 32'(cout), 32'(exp_cout));
         if (poke && i == 2) begin
            start = 1'b1;
            a     = 16'hAAAA;
            b     = 16'h5555;
            cin   = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
         end
      end
      @(negedge clk);
      check("done_pulse", 32'(done), 32'd1);
      check("done_busy", 32'(busy), 32'd0);
      check("sum", 32'(s), 32'(e[W-1:0]));
      check("cout", 32'(cout), 32'(e[W]));
      check("ovf", 32'(ovf), 32'(e[W+1]));
      exp_s    = e[W-1:0];
      exp_cout = e[W];
      exp_ovf  = e[W+1];
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      logic         rsub;
      n_cmp    = 0;
      n_err    = 0;
      exp_s    = '0;
      exp_cout = 1'b0;
      exp_ovf  = 1'b0;
      rst_n    = 1'b0;
      start    = 1'b0;
      a        = '0;
      b        = '0;
      cin      = 1'b0;
`ifdef RCA_SUB_EN
      sub_r    = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_s", 32'(s), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      rst_n = 1'b1;
      idle_cycle();

      run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
      check("dir_5555", 32'(s), 32'h5555);
      idle_cycle();
      run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
      check("dir_wrap_cout", 32'(cout), 32'd1);
      idle_cycle();
      run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
      check("dir_ovf", 32'(ovf), 32'd1);
      idle_cycle();
      run_op(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
      check("dir_cin", 32'(s), 32'h0001);
      idle_cycle();

      // Start pulsed during RUN must be ignored; next op starts in the DONE cycle.
      run_op(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1);
      check("ignored_start", 32'(s), 32'h0003);
      run_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, 1'b0);
      run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);
      idle_cycle();

      // Reset in RUN cycle 2 aborts with no done.
      start = 1'b1;
      a     = 16'h3333;
      b     = 16'h1111;
      cin   = 1'b0;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_s", 32'(s), 32'd0);
      check("abort_cout", 32'(cout), 32'd0);
      check("abort_ovf", 32'(ovf), 32'd0);
      exp_s    = '0;
      exp_cout = 1'b0;
      exp_ovf  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (ND + 2) idle_cycle();
      run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);
      check("post_abort", 32'(s), 32'h0100);
      idle_cycle();

`ifdef RCA_SUB_EN
      run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
      check("sub_neg", 32'(s), 32'hFFFE);
      check("sub_borrow", 32'(cout), 32'd0);
      idle_cycle();
      run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);
      check("sub_ovf_s", 32'(s), 32'h7FFF);
      check("sub_ovf", 32'(ovf), 32'd1);
      idle_cycle();
`endif

      for (int k = 0; k < 60; k++) begin
         ra   = W'($urandom);
         rb   = W'($urandom);
         rc   = 1'($urandom_range(0, 1));
         rsub = HAS_SUB ? 1'($urandom_range(0, 1)) : 1'b0;
         if ($urandom_range(0, 1) == 1) idle_cycle();
         run_op(ra, rb, rc, rsub, 1'b0);
      end
      idle_cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
